// File: rtl/sys_top.sv
// UART-driven command processor: RX deframer, command FSM, register file, ALU and TX framer.
// REG2 holds the UART configuration, which is sampled at the start bit of every frame.
module sys_top #(
  parameter int DATA_WIDTH = 8,
  parameter int RF_DEPTH   = 16
) (
  input  logic UART_CLK,
  input  logic RST_N,
  input  logic UART_RX_IN,
  output logic UART_TX_O,
  output logic parity_error,
  output logic framing_error
);

  localparam int AW = $clog2(RF_DEPTH);
  localparam int RW = 2 * DATA_WIDTH;
  localparam logic [3:0] DataBits = 4'(DATA_WIDTH);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StWrAddr  = 4'd1;
  localparam logic [3:0] StWrData  = 4'd2;
  localparam logic [3:0] StRdAddr  = 4'd3;
  localparam logic [3:0] StAluA    = 4'd4;
  localparam logic [3:0] StAluB    = 4'd5;
  localparam logic [3:0] StAluFunc = 4'd6;
  localparam logic [3:0] StExec    = 4'd7;
  localparam logic [3:0] StTxWait  = 4'd8;

  localparam logic [1:0] TxIdle  = 2'd0;
  localparam logic [1:0] TxFrame = 2'd1;
  localparam logic [1:0] TxGap   = 2'd2;

  logic [DATA_WIDTH-1:0] rf_q [RF_DEPTH];
  logic [5:0]            cfg_pre;

  // Only 8, 16 and 32 clocks per bit are supported; anything else runs at 32.
  always_comb begin
    cfg_pre = 6'd32;
    case (rf_q[2][7:2])
      6'd8:    cfg_pre = 6'd8;
      6'd16:   cfg_pre = 6'd16;
      default: cfg_pre = 6'd32;
    endcase
  end

  // ---------------- RX ----------------
  logic                  rx_sync_q, rx_prev_q, rx_busy_q;
  logic [5:0]            rx_cnt_q, rx_pre_q, rx_half;
  logic [3:0]            rx_bit_q;
  logic                  rx_par_en_q, rx_par_typ_q, rx_bad_par_q;
  logic [1:0]            rx_smp_q;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_byte_q;
  logic                  rx_valid_q, rx_err_q, rx_vote;

  assign rx_half = {1'b0, rx_pre_q[5:1]};
  assign rx_vote = (rx_smp_q[0] & rx_smp_q[1]) | (rx_smp_q[0] & rx_sync_q) |
                   (rx_smp_q[1] & rx_sync_q);

  always_ff @(posedge UART_CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_sync_q     <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_busy_q     <= 1'b0;
      rx_cnt_q      <= '0;
      rx_pre_q      <= 6'd32;
      rx_bit_q      <= '0;
      rx_par_en_q   <= 1'b0;
      rx_par_typ_q  <= 1'b0;
      rx_bad_par_q  <= 1'b0;
      rx_smp_q      <= '0;
      rx_shift_q    <= '0;
      rx_byte_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_err_q      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_sync_q  <= UART_RX_IN;
      rx_prev_q  <= rx_sync_q;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      if (!rx_busy_q) begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_busy_q    <= 1'b1;
          rx_cnt_q     <= '0;
          rx_bit_q     <= '0;
          rx_pre_q     <= cfg_pre;
          rx_par_en_q  <= rf_q[2][0];
          rx_par_typ_q <= rf_q[2][1];
          rx_bad_par_q <= 1'b0;
        end
      end else begin
        if (rx_cnt_q == rx_pre_q - 6'd1) begin
          rx_cnt_q <= '0;
          rx_bit_q <= rx_bit_q + 4'd1;
        end else begin
          rx_cnt_q <= rx_cnt_q + 6'd1;
        end
        if (rx_cnt_q == rx_half - 6'd1) rx_smp_q[0] <= rx_sync_q;
        if (rx_cnt_q == rx_half) rx_smp_q[1] <= rx_sync_q;
        if (rx_cnt_q == rx_half + 6'd1) begin
          if (rx_bit_q == 4'd0) begin
            if (rx_vote) begin
              rx_busy_q <= 1'b0;  // glitch, not a start bit
            end else begin
              parity_error  <= 1'b0;
              framing_error <= 1'b0;
            end
          end else if (rx_bit_q <= DataBits) begin
            rx_shift_q <= {rx_vote, rx_shift_q[DATA_WIDTH-1:1]};
          end else if (rx_par_en_q && rx_bit_q == DataBits + 4'd1) begin
            if (rx_vote != (^rx_shift_q ^ rx_par_typ_q)) begin
              rx_bad_par_q <= 1'b1;
              parity_error <= 1'b1;
            end
          end else begin
            rx_busy_q <= 1'b0;
            rx_byte_q <= rx_shift_q;
            if (!rx_vote) framing_error <= 1'b1;
            if (!rx_vote || rx_bad_par_q) rx_err_q <= 1'b1;
            else rx_valid_q <= 1'b1;
          end
        end
      end
    end
  end

  // ---------------- TX ----------------
  logic [1:0]            tx_state_q;
  logic [5:0]            tx_cnt_q, tx_pre_q;
  logic [3:0]            tx_bit_q, tx_last;
  logic                  tx_par_en_q, tx_par_q, tx_more_q, tx_done_q, tx_start, tx_line;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_load;
  logic                  tx_go_q, tx_two_q;
  logic [DATA_WIDTH-1:0] tx_lo_q, tx_hi_q;

  assign tx_last  = tx_par_en_q ? DataBits + 4'd2 : DataBits + 4'd1;
  assign tx_load  = (tx_state_q == TxIdle) ? tx_lo_q : tx_hi_q;
  assign tx_start = (tx_state_q == TxIdle && tx_go_q) ||
                    (tx_state_q == TxGap && tx_cnt_q == 6'd1);

  always_comb begin
    tx_line = 1'b1;
    if (tx_state_q == TxFrame) begin
      if (tx_bit_q == 4'd0) tx_line = 1'b0;
      else if (tx_bit_q <= DataBits) tx_line = tx_shift_q[0];
      else if (tx_par_en_q && tx_bit_q == DataBits + 4'd1) tx_line = tx_par_q;
    end
  end
  assign UART_TX_O = tx_line;

  always_ff @(posedge UART_CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_state_q  <= TxIdle;
      tx_cnt_q    <= '0;
      tx_pre_q    <= 6'd32;
      tx_bit_q    <= '0;
      tx_par_en_q <= 1'b0;
      tx_par_q    <= 1'b0;
      tx_more_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_shift_q  <= '0;
    end else begin
      tx_done_q <= 1'b0;
      if (tx_start) begin
        tx_state_q  <= TxFrame;
        tx_cnt_q    <= '0;
        tx_bit_q    <= '0;
        tx_shift_q  <= tx_load;
        tx_pre_q    <= cfg_pre;
        tx_par_en_q <= rf_q[2][0];
        tx_par_q    <= ^tx_load ^ rf_q[2][1];
        tx_more_q   <= (tx_state_q == TxIdle) && tx_two_q;
      end else if (tx_state_q == TxGap) begin
        tx_cnt_q <= tx_cnt_q + 6'd1;
      end else if (tx_state_q == TxFrame) begin
        if (tx_cnt_q == tx_pre_q - 6'd1) begin
          tx_cnt_q <= '0;
          tx_bit_q <= tx_bit_q + 4'd1;
          if (tx_bit_q != 4'd0 && tx_bit_q <= DataBits) tx_shift_q <= tx_shift_q >> 1;
          if (tx_bit_q == tx_last) begin
            if (tx_more_q) begin
              tx_state_q <= TxGap;
            end else begin
              tx_state_q <= TxIdle;
              tx_done_q  <= 1'b1;
            end
          end
        end else begin
          tx_cnt_q <= tx_cnt_q + 6'd1;
        end
      end
    end
  end

  // ---------------- ALU ----------------
  logic [RW-1:0] alu_a, alu_b, alu_res;
  logic [3:0]    func_q;

  assign alu_a = RW'(rf_q[0]);
  assign alu_b = RW'(rf_q[1]);

  always_comb begin
    alu_res = '0;
    case (func_q)
      4'h0:    alu_res = alu_a + alu_b;
      4'h1:    alu_res = alu_a - alu_b;
      4'h2:    alu_res = alu_a * alu_b;
      4'h3:    alu_res = (alu_b == '0) ? '0 : alu_a / alu_b;
      4'h4:    alu_res = alu_a & alu_b;
      4'h5:    alu_res = alu_a | alu_b;
      4'h6:    alu_res = RW'(~(rf_q[0] & rf_q[1]));
      4'h7:    alu_res = RW'(~(rf_q[0] | rf_q[1]));
      4'h8:    alu_res = alu_a ^ alu_b;
      4'h9:    alu_res = RW'(~(rf_q[0] ^ rf_q[1]));
      4'hA:    alu_res = RW'(rf_q[0] == rf_q[1]);
      4'hB:    alu_res = RW'(rf_q[0] > rf_q[1]);
      4'hC:    alu_res = RW'(rf_q[0] < rf_q[1]);
      4'hD:    alu_res = alu_a >> 1;
      4'hE:    alu_res = alu_a << 1;
      default: alu_res = '0;
    endcase
  end

  // ---------------- command FSM ----------------
  logic [3:0]    cmd_state_q;
  logic [AW-1:0] addr_q;
  logic          collecting;

  assign collecting = (cmd_state_q != StIdle) && (cmd_state_q != StExec) &&
                      (cmd_state_q != StTxWait);

  always_ff @(posedge UART_CLK or negedge RST_N) begin
    if (!RST_N) begin
      cmd_state_q <= StIdle;
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
      rf_q[2]     <= DATA_WIDTH'(8'h81);
      addr_q      <= '0;
      func_q      <= '0;
      tx_go_q     <= 1'b0;
      tx_two_q    <= 1'b0;
      tx_lo_q     <= '0;
      tx_hi_q     <= '0;
    end else begin
      tx_go_q <= 1'b0;
      if (rx_err_q && collecting) begin
        cmd_state_q <= StIdle;
      end else begin
        case (cmd_state_q)
          StIdle: if (rx_valid_q) begin
            case (rx_byte_q)
              8'hAA:   cmd_state_q <= StWrAddr;
              8'hBB:   cmd_state_q <= StRdAddr;
              8'hCC:   cmd_state_q <= StAluA;
              8'hDD:   cmd_state_q <= StAluFunc;
              default: cmd_state_q <= StIdle;
            endcase
          end
          StWrAddr: if (rx_valid_q) begin
            addr_q      <= rx_byte_q[AW-1:0];
            cmd_state_q <= StWrData;
          end
          StWrData: if (rx_valid_q) begin
            rf_q[addr_q] <= rx_byte_q;
            cmd_state_q  <= StIdle;
          end
          StRdAddr: if (rx_valid_q) begin
            tx_lo_q     <= rf_q[rx_byte_q[AW-1:0]];
            tx_two_q    <= 1'b0;
            tx_go_q     <= 1'b1;
            cmd_state_q <= StTxWait;
          end
          StAluA: if (rx_valid_q) begin
            rf_q[0]     <= rx_byte_q;
            cmd_state_q <= StAluB;
          end
          StAluB: if (rx_valid_q) begin
            rf_q[1]     <= rx_byte_q;
            cmd_state_q <= StAluFunc;
          end
          StAluFunc: if (rx_valid_q) begin
            func_q      <= rx_byte_q[3:0];
            cmd_state_q <= StExec;
          end
          StExec: begin
            tx_lo_q     <= alu_res[DATA_WIDTH-1:0];
            tx_hi_q     <= alu_res[RW-1:DATA_WIDTH];
            tx_two_q    <= 1'b1;
            tx_go_q     <= 1'b1;
            cmd_state_q <= StTxWait;
          end
          StTxWait: if (tx_done_q) cmd_state_q <= StIdle;
          default: cmd_state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sys_top.sv
// Directed bench for sys_top: drives UART command frames at 32 clocks/bit and decodes
// the response frames with a line monitor, checking each against hand-computed values.
module tb_sys_top;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic tx, pe, fe;

  always #5 clk = ~clk;

  sys_top dut (
    .UART_CLK     (clk),
    .RST_N        (rst_n),
    .UART_RX_IN   (rx),
    .UART_TX_O    (tx),
    .parity_error (pe),
    .framing_error(fe)
  );

  typedef struct packed {
    logic       start;
    logic [7:0] data;
    logic       par;
    logic       stop;
  } frame_t;

  frame_t q[$];
  int     n_cmp = 0;
  int     n_fail = 0;
  logic   mon_par_en = 1'b1;
  logic   bench_par = 1'b1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Response line monitor: samples each bit mid-way at 32 clocks/bit.
  initial begin
    forever begin : mon_blk
      frame_t f;
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        repeat (16) @(negedge clk);
        f.start = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (32) @(negedge clk);
          f.data[i] = tx;
        end
        if (mon_par_en) begin
          repeat (32) @(negedge clk);
          f.par = tx;
        end else begin
          f.par = 1'b0;
        end
        repeat (32) @(negedge clk);
        f.stop = tx;
        q.push_back(f);
      end
    end
  end

  task automatic put_bit(input logic v);
    rx = v;
    repeat (32) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic par_on, input logic bad_par,
                           input logic stop_bit);
    put_bit(1'b0);
    for (int i = 0; i < 8; i++) put_bit(b[i]);
    if (par_on) put_bit(^b ^ bad_par);
    put_bit(stop_bit);
    rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic sb(input logic [7:0] b);
    send_byte(b, bench_par, 1'b0, 1'b1);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic p);
    frame_t f;
    int t = 0;
    while (q.size() == 0 && t < 1500) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_rcv"}, 16'(q.size() != 0), 16'd1);
    if (q.size() != 0) begin
      f = q.pop_front();
      check({tag, "_start"}, 16'(f.start), 16'd0);
      check({tag, "_data"}, 16'(f.data), 16'(d));
      if (mon_par_en) check({tag, "_par"}, 16'(f.par), 16'(p));
      check({tag, "_stop"}, 16'(f.stop), 16'd1);
    end
  endtask

  task automatic quiet_check(input string tag, input int cycles);
    int lows = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check(tag, 16'(lows + q.size()), 16'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk);
    check("rst_tx", 16'(tx), 16'd1);
    check("rst_pe", 16'(pe), 16'd0);
    check("rst_fe", 16'(fe), 16'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // REG2 reset value read back
    sb(8'hBB); sb(8'h02);
    expect_frame("rd_reg2", 8'h81, 1'b0);
    quiet_check("rd_reg2_end", 60);

    sb(8'hAA); sb(8'h07); sb(8'hCD);
    quiet_check("wr_noresp", 400);
    sb(8'hBB); sb(8'h07);
    expect_frame("rd_cd", 8'hCD, 1'b1);
    quiet_check("rd_cd_end", 60);

    sb(8'hCC); sb(8'h0A); sb(8'h04); sb(8'h00);
    expect_frame("add_lo", 8'h0E, 1'b1);
    expect_frame("add_hi", 8'h00, 1'b0);
    quiet_check("add_end", 60);

    sb(8'hCC); sb(8'h0A); sb(8'hC8); sb(8'h02);
    expect_frame("mul_lo", 8'hD0, 1'b1);
    expect_frame("mul_hi", 8'h07, 1'b1);
    quiet_check("mul_end", 60);

    sb(8'hCC); sb(8'h07); sb(8'h04); sb(8'h01);
    expect_frame("sub_lo", 8'h03, 1'b0);
    expect_frame("sub_hi", 8'h00, 1'b0);
    quiet_check("sub_end", 60);

    sb(8'hDD); sb(8'h02);
    expect_frame("dmul_lo", 8'h1C, 1'b1);
    expect_frame("dmul_hi", 8'h00, 1'b0);
    quiet_check("dmul_end", 60);

    sb(8'hDD); sb(8'h00);
    expect_frame("dadd_lo", 8'h0B, 1'b1);
    expect_frame("dadd_hi", 8'h00, 1'b0);
    quiet_check("dadd_end", 60);

    // Parity off from the next frame onwards
    sb(8'hAA); sb(8'h02); sb(8'h80);
    bench_par = 1'b0;
    mon_par_en = 1'b0;
    sb(8'hAA); sb(8'h05); sb(8'h45);
    sb(8'hBB); sb(8'h05);
    expect_frame("np_rd", 8'h45, 1'b0);
    quiet_check("np_end", 60);

    // Parity back on, then a bad-parity address byte must abort the write
    sb(8'hAA); sb(8'h02); sb(8'h81);
    bench_par = 1'b1;
    mon_par_en = 1'b1;
    sb(8'hAA);
    send_byte(8'h05, 1'b1, 1'b1, 1'b1);
    check("perr_set", 16'(pe), 16'd1);
    check("perr_fe", 16'(fe), 16'd0);
    sb(8'hBB); sb(8'h05);
    check("perr_clr", 16'(pe), 16'd0);
    expect_frame("perr_rd", 8'h45, 1'b1);
    quiet_check("perr_end", 60);

    send_byte(8'h00, 1'b1, 1'b0, 1'b0);
    check("ferr_set", 16'(fe), 16'd1);
    check("ferr_pe", 16'(pe), 16'd0);
    sb(8'h00);
    check("ferr_clr", 16'(fe), 16'd0);

    // Two-clock glitch
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    quiet_check("glitch_quiet", 80);
    check("glitch_pe", 16'(pe), 16'd0);
    check("glitch_fe", 16'(fe), 16'd0);
    sb(8'hBB); sb(8'h07);
    expect_frame("glitch_rd", 8'hCD, 1'b1);
    quiet_check("glitch_end", 60);

    // Reset in the middle of an incoming frame
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_tx", 16'(tx), 16'd1);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    sb(8'hBB); sb(8'h07);
    expect_frame("midrst_rd", 8'h00, 1'b0);
    quiet_check("midrst_end", 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_top.md
SYS_TOP -- requirements
Module: sys_top

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of UART data bytes, register file entries and ALU operands.
REQ-002 SHALL have parameter RF_DEPTH, default 16, number of register file entries; the address is the low 4 bits of the address byte.
REQ-003 SHALL have port UART_CLK, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port RST_N, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port UART_RX_IN, input, 1, serial command input, idle high.
REQ-006 SHALL have port UART_TX_O, output, 1, serial response output, idle high.
REQ-007 SHALL have port parity_error, output, 1, high from detection of a bad RX parity bit until the next start bit is accepted.
REQ-008 SHALL have port framing_error, output, 1, high from detection of a low RX stop bit until the next start bit is accepted.

Function
REQ-009 SHALL use register REG2 as UART configuration: bit0 PAR_EN, bit1 PAR_TYP (0 even, 1 odd), bits[7:2] PRESCALE (clocks per bit); PRESCALE values 8, 16 and 32 are legal, and any other value SHALL behave as 32.
REQ-010 SHALL use the frame format start(0), 8 data bits LSB first, parity bit only when PAR_EN=1, stop(1), each bit lasting PRESCALE clocks, in both RX and TX.
REQ-011 SHALL latch the configuration at the start bit of each RX/TX frame, so a REG2 write affects only the next frame.
REQ-012 RX SHALL detect a falling edge while idle, then majority-vote three samples at PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1 of each bit.
REQ-013 RX SHALL return to idle without error if the start-bit vote is 1 (glitch).
REQ-014 RX SHALL compute parity as even = XOR of data bits and odd = its inverse; on mismatch it sets parity_error and discards the byte.
REQ-015 RX SHALL set framing_error and discard the byte on a stop-bit vote of 0; valid bytes are delivered to the command FSM as a one-clock strobe.
REQ-016 Command FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUNC, EXEC, TX_WAIT.
REQ-017 IDLE SHALL accept 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->ALU_A and 0xDD->ALU_FUNC, and ignore any other byte.
REQ-018 0xAA addr data SHALL write data to RF[addr] with no response.
REQ-019 0xBB addr SHALL transmit one frame carrying RF[addr].
REQ-020 0xCC A B func SHALL write A to REG0 and B to REG1, execute func, and transmit the 16-bit result.
REQ-021 0xDD func SHALL execute func on the current REG0 and REG1 and transmit the 16-bit result.
REQ-022 The 16-bit result SHALL be transmitted as two frames, low byte first then high byte, with the line held idle high for 1-4 clocks between frames.
REQ-023 ALU functions (A=REG0, B=REG1, result is 16 bits): 0 A+B; 1 A-B mod 2^16; 2 A*B; 3 A/B integer (0 if B=0); 4 AND; 5 OR; 6 NAND; 7 NOR; 8 XOR; 9 XNOR (each logic op zero-extended); A (A==B); B (A>B); C (A<B); D A>>1; E A<<1; F 0.
REQ-024 The first TX start bit SHALL begin within 4 clocks after the final command byte is accepted.
REQ-025 TX_WAIT SHALL last until all response frames have been sent; RX bytes accepted during TX_WAIT SHALL be dropped.
REQ-026 A discarded (errored) RX byte in any non-IDLE state SHALL abort the command and return the FSM to IDLE with no RF write and no response.
REQ-027 The register file SHALL be RF_DEPTH x 8; writes to REG2 reconfigure the UART per REQ-011.

Reset
REQ-028 While RST_N=0: UART_TX_O=1, parity_error=0, framing_error=0, FSM=IDLE, RX/TX idle.
REQ-029 While RST_N=0: all RF entries 0, except REG2=0x81 (parity on, even, PRESCALE=32).
REQ-030 Reset asserted mid-frame SHALL abort immediately; normal operation resumes at the first falling edge after release.

Verification
REQ-031 Bench SHALL apply reset, then send AA 07 CD, then BB 07 -> one TX frame 0,CD LSB-first,parity 1,1.
REQ-032 Bench SHALL send CC 0A 04 00 -> frames 0x0E then 0x00; then CC 0A C8 02 -> 0xD0 then 0x07 (2000).
REQ-033 Bench SHALL send CC 07 04 01 -> 0x0003; then DD 02 -> 0x001C; then DD 00 -> 0x000B.
REQ-034 Bench SHALL send AA 02 80 (parity off, PRESCALE 32), then AA 05 45 and BB 05 as 10-bit frames -> 10-bit response frame carrying 0x45.
REQ-035 Bench SHALL send a byte with a wrong parity bit after AA -> parity_error=1, no RF write, FSM back in IDLE; send a frame with stop bit 0 -> framing_error=1.
REQ-036 Bench SHALL send a 2-clock low glitch on UART_RX_IN -> no byte accepted and no error flag set.
